// File: rtl/wagu_pkg.sv
// Shared definitions for the weight address generation unit: mode codes,
// FSM state type and default widths.
package wagu_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned LEN_W_DEF  = 8;
    localparam int unsigned K_W_DEF    = 4;

    localparam logic [3:0] MODE_CONV = 4'd1;
    localparam logic [3:0] MODE_ADD  = 4'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

endpackage

// File: rtl/wagu_if.sv
// Scheduler/decoder configuration, weight-buffer read port and status of the weight AGU.
interface wagu_if
    import wagu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned K_W    = K_W_DEF
);
    logic              start_calculate;
    logic [3:0]        mode;
    logic [ADDR_W:0]   addr_start_w;
    logic [LEN_W-1:0]  out_x_length;
    logic [LEN_W-1:0]  out_y_length;
    logic [LEN_W-1:0]  in_piece;
    logic [K_W-1:0]    k_size;
    logic              i_ready;
    logic [ADDR_W-1:0] o_w_addr;
    logic              o_rd_en;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        output start_calculate, mode, addr_start_w, out_x_length, out_y_length, in_piece, k_size,
        output i_ready,
        input  o_w_addr, o_rd_en, o_busy, o_done, o_err
    );

    modport slave (
        input  start_calculate, mode, addr_start_w, out_x_length, out_y_length, in_piece, k_size,
        input  i_ready,
        output o_w_addr, o_rd_en, o_busy, o_done, o_err
    );

endinterface

// File: rtl/wagu_loop_cnt.sv
// Wrap counter for one loop level: counts 0..limit-1 on enable, flags the final value.
module wagu_loop_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == limit - W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/wagu_gen.sv
// Weight address generator: walks piece/row/column/tap loops issuing one
// weight-buffer read per accepted step, in ADD or KxK CONV mode.
module wagu_gen
    import wagu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned K_W    = K_W_DEF
) (
    input logic   clk,
    input logic   rst,
    wagu_if.slave bus
);

    localparam int unsigned KK_W = 2 * K_W;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q, piece_base_q, piece_base_d, addr_q, addr_d;
    logic [LEN_W-1:0]  x_len_q, y_len_q, p_len_q;
    logic [LEN_W-1:0]  x_cnt, y_cnt, p_cnt;
    logic [KK_W-1:0]   kk_q, kk_start, k_cnt, k_d;
    logic              k_last, x_last, y_last, p_last;
    logic              rd_en_q, busy_q, done_q, err_q;
    logic              accept, cnt_clr, is_conv, is_legal, is_empty;
    logic              unused_bits;

    // Only the wrap flags of the outer loops feed the address; the MSB of the base is ignored.
    assign unused_bits = ^{bus.addr_start_w[ADDR_W], x_cnt, y_cnt, p_cnt};

    assign accept  = (state_q == StRun) && rd_en_q && bus.i_ready;
    assign cnt_clr = (state_q == StIdle) && bus.start_calculate;

    wagu_loop_cnt #(.W(KK_W)) u_k_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(accept),
        .limit(kk_q), .cnt(k_cnt), .last(k_last)
    );
    wagu_loop_cnt #(.W(LEN_W)) u_x_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(accept && k_last),
        .limit(x_len_q), .cnt(x_cnt), .last(x_last)
    );
    wagu_loop_cnt #(.W(LEN_W)) u_y_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(accept && k_last && x_last),
        .limit(y_len_q), .cnt(y_cnt), .last(y_last)
    );
    wagu_loop_cnt #(.W(LEN_W)) u_p_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(accept && k_last && x_last && y_last),
        .limit(p_len_q), .cnt(p_cnt), .last(p_last)
    );

    always_comb begin
        is_conv  = (bus.mode == MODE_CONV);
        is_legal = is_conv || (bus.mode == MODE_ADD);
        kk_start = is_conv ? KK_W'(bus.k_size) * KK_W'(bus.k_size) : KK_W'(1);
        is_empty = (bus.out_x_length == '0) || (bus.out_y_length == '0) ||
                   (bus.in_piece == '0) || (is_conv && (bus.k_size == '0));
        k_d      = k_last ? '0 : k_cnt + KK_W'(1);
        // piece_base tracks p*KK incrementally so no multiplier sits in the address path.
        piece_base_d = (k_last && x_last && y_last) ? piece_base_q + ADDR_W'(kk_q)
                                                    : piece_base_q;
        addr_d   = base_q + piece_base_d + ADDR_W'(k_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            base_q       <= '0;
            piece_base_q <= '0;
            addr_q       <= '0;
            x_len_q      <= '0;
            y_len_q      <= '0;
            p_len_q      <= '0;
            kk_q         <= '0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_calculate) begin
                        base_q       <= bus.addr_start_w[ADDR_W-1:0];
                        x_len_q      <= bus.out_x_length;
                        y_len_q      <= bus.out_y_length;
                        p_len_q      <= bus.in_piece;
                        kk_q         <= kk_start;
                        piece_base_q <= '0;
                        if (!is_legal || is_empty) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                            err_q   <= !is_legal;
                        end else begin
                            state_q <= StRun;
                            rd_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                            addr_q  <= bus.addr_start_w[ADDR_W-1:0];
                        end
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (k_last && x_last && y_last && p_last) begin
                            state_q <= StFin;
                            rd_en_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q       <= addr_d;
                            piece_base_q <= piece_base_d;
                        end
                    end
                end
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_w_addr = addr_q;
    assign bus.o_rd_en  = rd_en_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_err    = err_q;

endmodule

// File: tb/tb_wagu_gen.sv
// Self-checking bench for wagu_gen: vector table, hand-written corner sequences and
// randomized jobs compared against a nested-loop address model.
module tb_wagu_gen;
    import wagu_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned BW = AW + 1;
    localparam int unsigned LW = 8;
    localparam int unsigned KW = 4;

    typedef struct {
        logic [3:0] mode;
        int         base;
        int         x;
        int         y;
        int         p;
        int         k;
        int         rdy;        // 0: always ready, 1: toggle 1/0, 2: random
        int         exp_reads;
        int         exp_first;
        int         exp_last;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wagu_if #(.ADDR_W(AW), .LEN_W(LW), .K_W(KW)) bus ();

    wagu_gen #(.ADDR_W(AW), .LEN_W(LW), .K_W(KW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int got_q[$];
    int exp_q[$];
    int ndone, nerr, err_alone, hold_bad, busy_bad, done_cyc, last_acc, post_done;
    bit timed_out;

    vec_t tbl[8];

    function automatic void check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endfunction

    // Reference: plain nested loops over pieces, rows, columns and taps.
    function automatic bit model(input vec_t v);
        int kk;
        exp_q.delete();
        if (!(v.mode == MODE_ADD || v.mode == MODE_CONV)) return 1'b1;
        kk = (v.mode == MODE_CONV) ? v.k * v.k : 1;
        if (v.x == 0 || v.y == 0 || v.p == 0 || kk == 0) return 1'b0;
        for (int p = 0; p < v.p; p++)
            for (int y = 0; y < v.y; y++)
                for (int x = 0; x < v.x; x++)
                    for (int k = 0; k < kk; k++)
                        exp_q.push_back((v.base + p * kk + k) % (1 << AW));
        return 1'b0;
    endfunction

    task automatic drive_cfg(input vec_t v);
        bus.mode         = v.mode;
        bus.addr_start_w = BW'(v.base);
        bus.out_x_length = LW'(v.x);
        bus.out_y_length = LW'(v.y);
        bus.in_piece     = LW'(v.p);
        bus.k_size       = KW'(v.k);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after o_done.
    task automatic run_job(input vec_t v, input int restart_cyc);
        int               cyc;
        bit               rdy, prev_stall, done;
        logic [AW-1:0]    prev_addr;
        got_q.delete();
        ndone = 0; nerr = 0; err_alone = 0; hold_bad = 0; busy_bad = 0;
        done_cyc = -1; last_acc = -1; timed_out = 1'b0;
        drive_cfg(v);
        bus.start_calculate = 1'b1;
        bus.i_ready         = 1'b1;
        @(negedge clk);
        bus.start_calculate = 1'b0;
        prev_stall = 1'b0; prev_addr = '0; done = 1'b0; cyc = 0;
        while (!done) begin
            if (cyc >= 5000) begin
                timed_out = 1'b1;
                break;
            end
            case (v.rdy)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = ($urandom_range(9) < 7);
            endcase
            bus.i_ready = rdy;
            bus.start_calculate = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                bus.addr_start_w = BW'(500);
                bus.out_x_length = LW'(5);
            end
            if (prev_stall && (!bus.o_rd_en || bus.o_w_addr != prev_addr)) hold_bad++;
            if (bus.o_rd_en && !bus.o_busy) busy_bad++;
            if (bus.o_err && !bus.o_done) err_alone++;
            if (bus.o_rd_en && rdy) begin
                got_q.push_back(int'(bus.o_w_addr));
                last_acc = cyc;
            end
            prev_stall = bus.o_rd_en && !rdy;
            prev_addr  = bus.o_w_addr;
            if (bus.o_done) begin
                ndone++;
                done_cyc = cyc;
                if (bus.o_err) nerr++;
                if (bus.o_busy || bus.o_rd_en) busy_bad++;
                done = 1'b1;
            end
            cyc++;
            @(negedge clk);
            bus.start_calculate = 1'b0;
        end
        post_done = int'(bus.o_done);
    endtask

    task automatic eval_job(input string tag, input vec_t v, input bit use_tbl);
        bit exp_err;
        int mism;
        exp_err = model(v);
        check({tag, " timeout"}, int'(timed_out), 0);
        check({tag, " read count"}, got_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) mism++;
        check({tag, " address mismatches"}, mism, 0);
        if (use_tbl) begin
            check({tag, " table reads"}, got_q.size(), v.exp_reads);
            check({tag, " table err"}, nerr, int'(v.exp_err));
            if (v.exp_reads > 0 && got_q.size() > 0) begin
                check({tag, " first addr"}, got_q[0], v.exp_first);
                check({tag, " last addr"}, got_q[got_q.size()-1], v.exp_last);
            end
        end
        check({tag, " done pulses"}, ndone, 1);
        check({tag, " err with done"}, nerr, int'(exp_err));
        check({tag, " err without done"}, err_alone, 0);
        check({tag, " done is one cycle"}, post_done, 0);
        check({tag, " done timing"}, done_cyc, (exp_q.size() == 0) ? 0 : last_acc + 1);
        check({tag, " addr hold on stall"}, hold_bad, 0);
        check({tag, " busy consistency"}, busy_bad, 0);
    endtask

    initial begin
        vec_t v;
        int   cnt_done, cnt_rd;

        tbl[0] = '{MODE_ADD,  0,          2, 2, 2, 0,  0, 8,   0,    1,   1'b0};
        tbl[1] = '{MODE_CONV, 100,        1, 1, 1, 3,  0, 9,   100,  108, 1'b0};
        tbl[2] = '{MODE_CONV, 0,          1, 2, 2, 2,  1, 16,  0,    7,   1'b0};
        tbl[3] = '{4'd7,      0,          2, 2, 2, 3,  0, 0,   0,    0,   1'b1};
        tbl[4] = '{MODE_ADD,  0,          2, 2, 0, 0,  0, 0,   0,    0,   1'b0};
        tbl[5] = '{MODE_ADD,  4094,       1, 1, 3, 0,  0, 3,   4094, 0,   1'b0};
        tbl[6] = '{MODE_CONV, 8,          2, 2, 2, 0,  0, 0,   0,    0,   1'b0};
        tbl[7] = '{MODE_CONV, 4000 + 4096, 1, 1, 1, 15, 2, 225, 4000, 128, 1'b0};

        rst = 1'b1;
        bus.start_calculate = 1'b0;
        bus.i_ready = 1'b0;
        drive_cfg(tbl[0]);
        repeat (2) @(negedge clk);
        check("reset outputs", int'({bus.o_rd_en, bus.o_busy, bus.o_done, bus.o_err}), 0);
        check("reset addr", int'(bus.o_w_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i], -1);
            eval_job($sformatf("vec%0d", i), tbl[i], 1'b1);
        end

        // Second start while running must be ignored.
        v = tbl[0];
        run_job(v, 3);
        eval_job("restart ignored", v, 1'b0);

        // Asynchronous reset in the middle of a run.
        v = '{MODE_ADD, 0, 4, 4, 4, 0, 0, 64, 0, 3, 1'b0};
        drive_cfg(v);
        bus.i_ready = 1'b1;
        bus.start_calculate = 1'b1;
        @(negedge clk);
        bus.start_calculate = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset rd_en", int'(bus.o_rd_en), 1);
        #2 rst = 1'b1;
        #1;
        check("mid-run reset outputs",
              int'({bus.o_rd_en, bus.o_busy, bus.o_done, bus.o_err}), 0);
        check("mid-run reset addr", int'(bus.o_w_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0; cnt_rd = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.o_done) cnt_done++;
            if (bus.o_rd_en) cnt_rd++;
        end
        check("no done after abort", cnt_done, 0);
        check("no reads after abort", cnt_rd, 0);

        for (int i = 0; i < 25; i++) begin
            int r;
            r = $urandom_range(9);
            v.mode = (r < 4) ? MODE_CONV : (r < 8) ? MODE_ADD : 4'($urandom_range(15));
            v.base = $urandom_range(8191);
            v.x = $urandom_range(3);
            v.y = $urandom_range(3);
            v.p = $urandom_range(3);
            v.k = $urandom_range(4);
            v.rdy = 2;
            v.exp_reads = 0; v.exp_first = 0; v.exp_last = 0; v.exp_err = 1'b0;
            run_job(v, -1);
            eval_job($sformatf("rand%0d", i), v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
